// File: rtl/vga_ram_writer_pkg.sv
// Shared definitions for the VGA framebuffer write path: RAM geometry,
// FSM state encodings and the byte-lane merge helper.
package vga_ram_writer_pkg;

    localparam int VGA_ADDR_W = 14;
    localparam int VGA_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_CLR  = 2'd3
    } state_t;

    // Replace one 8-bit pixel lane of a RAM word (lane 0 = [7:0], lane 1 = [15:8]).
    function automatic logic [VGA_DATA_W-1:0] merge_lane(
        input logic [VGA_DATA_W-1:0] word,
        input logic                  lane,
        input logic [7:0]            pixel
    );
        logic [VGA_DATA_W-1:0] res;
        res = word;
        if (lane) res[15:8] = pixel;
        else      res[7:0]  = pixel;
        return res;
    endfunction

endpackage

// File: rtl/vga_ram_writer_fifo.sv
// vga_wr_fifo: synchronous FIFO for pending CPU byte writes.
// Pushes while full are dropped; full/empty derive from the registered count.
module vga_wr_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/vga_ram_writer.sv
// vga_ram_writer: write-side controller for the VGA framebuffer RAM port B.
// CPU byte writes are queued, then applied as a read-modify-write of the
// 16-bit word. Optional full-screen clear is built when VGA_CLEAR_EN is defined.
module vga_ram_writer
    import vga_ram_writer_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = VGA_ADDR_W,
    parameter int DATA_W     = VGA_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W:0]   wr_addr,
    input  logic [7:0]        wr_data,
    output logic              wr_ready,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_value,
    output logic              clr_done
);

    localparam int ENTRY_W = ADDR_W + 1 + 8;

    state_t                    state;
    logic                      lane;
    logic [7:0]                pixel;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [ENTRY_W-1:0]        fifo_dout;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                      unused_count;

    assign unused_count = ^fifo_count;

    vga_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_req),
        .pop   (fifo_pop),
        .din   ({wr_addr, wr_data}),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign wr_ready = !fifo_full;
    assign busy     = !fifo_empty || (state != ST_IDLE);

`ifdef VGA_CLEAR_EN
    // A clear request in IDLE wins over the pop.
    assign fifo_pop = (state == ST_IDLE) && !fifo_empty && !clr_start;
`else
    logic unused_clr;
    assign unused_clr = clr_start ^ (^clr_value);
    assign fifo_pop   = (state == ST_IDLE) && !fifo_empty;
`endif

    // Write FSM: IDLE pops and addresses the word, RD waits for read data,
    // WR merges the byte and pulses ram_we; CLR sweeps the whole RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ram_addr <= '0;
            ram_din  <= '0;
            ram_we   <= 1'b0;
            clr_done <= 1'b0;
            lane     <= 1'b0;
            pixel    <= '0;
        end else begin
            ram_we   <= 1'b0;
            clr_done <= 1'b0;
            case (state)
                ST_IDLE: begin
`ifdef VGA_CLEAR_EN
                    if (clr_start) begin
                        ram_addr <= '0;
                        ram_din  <= clr_value;
                        ram_we   <= 1'b1;
                        state    <= ST_CLR;
                    end else
`endif
                    if (!fifo_empty) begin
                        ram_addr <= fifo_dout[ENTRY_W-1:9];
                        lane     <= fifo_dout[8];
                        pixel    <= fifo_dout[7:0];
                        state    <= ST_RD;
                    end
                end
                ST_RD: begin
                    state <= ST_WR;
                end
                ST_WR: begin
                    ram_din <= merge_lane(ram_dout, lane, pixel);
                    ram_we  <= 1'b1;
                    state   <= ST_IDLE;
                end
`ifdef VGA_CLEAR_EN
                ST_CLR: begin
                    // ram_din still holds the fill word captured at start.
                    if (ram_addr == '1) begin
                        clr_done <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        ram_addr <= ram_addr + 1'b1;
                        ram_we   <= 1'b1;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_ram_writer.sv
// Testbench for vga_ram_writer: behavioural port-B RAM (read-first), a
// scoreboard of expected {ram_addr, ram_din} writes checked by a monitor
// on every ram_we cycle, plus directed reset/latency/backpressure checks.
// Build with +define+VGA_CLEAR_EN to exercise the clear sweep.
`timescale 1ns/1ps
module tb_vga_ram_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_req;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        busy;
    logic [13:0] ram_addr;
    logic [15:0] ram_din;
    logic        ram_we;
    logic [15:0] ram_dout;
    logic        clr_start;
    logic [15:0] clr_value;
    logic        clr_done;

    logic [15:0] ram_mem [16384];
    logic [29:0] sb [$];
    int          checks;
    int          errors;
    int          done_pulses;

`ifdef VGA_CLEAR_EN
    localparam int EXP_PULSES = 1;
`else
    localparam int EXP_PULSES = 0;
`endif

    vga_ram_writer #(
        .FIFO_DEPTH (8),
        .ADDR_W     (14),
        .DATA_W     (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .busy      (busy),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout),
        .clr_start (clr_start),
        .clr_value (clr_value),
        .clr_done  (clr_done)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic ram_model();
        logic [15:0] rd;
        forever begin
            @(posedge clk);
            rd = ram_mem[ram_addr];
            if (ram_we) ram_mem[ram_addr] = ram_din;
            ram_dout <= rd;
        end
    endtask

    task automatic monitor();
        logic [29:0] exp;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ram_we) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write: addr=%h din=%h with no write pending", ram_addr, ram_din);
                    end else begin
                        exp = sb.pop_front();
                        if ({ram_addr, ram_din} !== exp) begin
                            errors++;
                            $display("FAIL ram_write: addr=%h din=%h expected addr=%h din=%h",
                                     ram_addr, ram_din, exp[29:16], exp[15:0]);
                        end
                    end
                end
                if (clr_done) begin
                    done_pulses++;
                    chk("clr_done_order", sb.size(), 1);
                end
            end
        end
    endtask

    task automatic push_byte(input logic [14:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1 wr_req = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (!busy && !ram_we) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%b ram_we=%b after %0d cycles", busy, ram_we, limit);
        end
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int first_low;
        int accepted;
        bit seen;

        checks = 0; errors = 0; done_pulses = 0;
        rst = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        clr_start = 1'b0; clr_value = '0; ram_dout = '0;
        for (int i = 0; i < 16384; i++) ram_mem[i] = '0;

        fork
            ram_model();
            monitor();
            begin
                #2_000_000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // power-up reset state
        repeat (3) @(negedge clk);
        chk("rst_ram_we",   ram_we,   0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_busy",     busy,     0);
        chk("rst_clr_done", clr_done, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_din",  ram_din,  0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single lane-1 write plus latency from the accepting edge
        ram_mem[14'h0010] = 16'hABCD;
        sb.push_back({14'h0010, 16'h5ECD});
        push_byte(15'h0021, 8'h5E);
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            #1;
            if (ram_we) begin
                lat = n;
                break;
            end
        end
        chk("we_latency", lat, 3);
        wait_idle(50);

        // back-to-back bytes into the same word
        ram_mem[14'h0040] = 16'h0000;
        sb.push_back({14'h0040, 16'h0011});
        sb.push_back({14'h0040, 16'h2211});
        @(negedge clk);
        wr_req = 1'b1; wr_addr = 15'h0080; wr_data = 8'h11;
        @(negedge clk);
        wr_addr = 15'h0081; wr_data = 8'h22;
        @(negedge clk);
        wr_req = 1'b0;
        wait_idle(50);
        chk("same_word_merge", ram_mem[14'h0040], 16'h2211);

        // asynchronous reset mid-cycle while ram_we is high
        ram_mem[14'h0080] = 16'h1234;
        sb.push_back({14'h0080, 16'h9934});
        push_byte(15'h0101, 8'h99);
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (ram_we) begin
                seen = 1'b1;
                break;
            end
        end
        chk("we_seen_before_rst", seen, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_ram_we",   ram_we,   0);
        chk("async_wr_ready", wr_ready, 1);
        chk("async_busy",     busy,     0);
        chk("async_clr_done", clr_done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // held request: backpressure at count 8, accepted bytes only
        first_low = -1;
        accepted  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            wr_req  = 1'b1;
            wr_addr = {14'(32'h100 + i), 1'b0};
            wr_data = 8'(32'h30 + i);
            if (wr_ready) begin
                accepted++;
                sb.push_back({14'(32'h100 + i), 8'h00, 8'(32'h30 + i)});
            end else if (first_low < 0) begin
                first_low = i;
            end
        end
        @(negedge clk);
        wr_req = 1'b0;
        chk("first_not_ready_cycle", first_low, 12);
        chk("accepted_bytes",        accepted,  14);
        wait_idle(200);

        // reset while in RD: the entry is abandoned
        push_byte(15'h0300, 8'h55);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rd_rst_busy",     busy,     0);
        chk("rd_rst_wr_ready", wr_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("rd_rst_idle_busy", busy, 0);
        ram_mem[14'h0181] = 16'h0F0F;
        sb.push_back({14'h0181, 16'h0FA5});
        push_byte(15'h0302, 8'hA5);
        wait_idle(50);

`ifdef VGA_CLEAR_EN
        // full-screen clear with one byte queued behind it
        for (int i = 0; i < 16384; i++) sb.push_back({14'(i), 16'h0303});
        sb.push_back({14'h0100, 16'h7703});
        @(negedge clk);
        clr_value = 16'h0303;
        clr_start = 1'b1;
        wr_req    = 1'b1;
        wr_addr   = 15'h0201;
        wr_data   = 8'h77;
        @(posedge clk);
        #1;
        clr_start = 1'b0;
        wr_req    = 1'b0;
        wait_idle(20000);
`endif

        chk("scoreboard_drained", sb.size(), 0);
        chk("clr_done_pulses",    done_pulses, EXP_PULSES);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
